// File: rtl/exu_alu_issue_pkg.sv
// -----------------------------------------------------------------------------
// exu_alu_issue_pkg
// Shared definitions for the execute-stage ALU issue block: datapath width,
// ALU op codes, operand masks and the issue FSM state type.
// -----------------------------------------------------------------------------
package exu_alu_issue_pkg;

    localparam int XLEN = 64;

    localparam logic [7:0] ALU_ADD  = 8'd0;
    localparam logic [7:0] ALU_SUB  = 8'd1;
    localparam logic [7:0] ALU_SLT  = 8'd2;
    localparam logic [7:0] ALU_SLTU = 8'd3;
    localparam logic [7:0] ALU_AND  = 8'd4;
    localparam logic [7:0] ALU_OR   = 8'd6;
    localparam logic [7:0] ALU_XOR  = 8'd7;
    localparam logic [7:0] ALU_SLL  = 8'd8;
    localparam logic [7:0] ALU_SRA  = 8'd10;

    localparam logic [XLEN-1:0] SIGN_BIT    = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] SHAMT_MASK  = 64'd63;
    localparam logic [XLEN-1:0] SHAMTW_MASK = 64'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Op codes that have an RV64 *W form.
    function automatic logic word_capable(input logic [7:0] mode);
        return (mode == ALU_ADD) || (mode == ALU_SUB) ||
               (mode == ALU_SLL) || (mode == ALU_SRA);
    endfunction

endpackage

// File: rtl/exu_alu_opnd_prep.sv
// -----------------------------------------------------------------------------
// exu_alu_opnd_prep
// Combinational operand conditioning for the external unsigned 64-bit ALU:
// legality check, sign-bias for signed SLT, shift-amount masking and
// sign-extension of A for word arithmetic shifts.
// Ports:
//   i_mode  [7:0]   ALU op code
//   i_word          RV64 *W variant
//   i_a, i_b [63:0] raw operands
//   o_legal         op code / word combination supported
//   o_a, o_b [63:0] conditioned operands for the ALU
// -----------------------------------------------------------------------------
module exu_alu_opnd_prep
    import exu_alu_issue_pkg::*;
(
    input  logic [7:0]      i_mode,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_legal,
    output logic [XLEN-1:0] o_a,
    output logic [XLEN-1:0] o_b
);

    logic w_mode_ok;

    always_comb begin
        case (i_mode)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
            ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA: w_mode_ok = 1'b1;
            default:                           w_mode_ok = 1'b0;
        endcase
    end

    assign o_legal = w_mode_ok && (!i_word || word_capable(i_mode));

    always_comb begin
        o_a = i_a;
        o_b = i_b;
        case (i_mode)
            // Flipping the sign bit of both operands maps signed order onto
            // unsigned order, so the ALU's unsigned compare yields signed SLT.
            ALU_SLT: begin
                o_a = i_a ^ SIGN_BIT;
                o_b = i_b ^ SIGN_BIT;
            end
            ALU_SLL: begin
                o_b = i_b & (i_word ? SHAMTW_MASK : SHAMT_MASK);
            end
            ALU_SRA: begin
                o_b = i_b & (i_word ? SHAMTW_MASK : SHAMT_MASK);
                // Word SRA must shift in bit 31, not bit 63.
                if (i_word) begin
                    o_a = {{32{i_a[31]}}, i_a[31:0]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exu_alu_issue.sv
// -----------------------------------------------------------------------------
// exu_alu_issue
// Execute-stage initiator for the combinational 64-bit ALU. Accepts one decoded
// op (valid/ready), drives the ALU for one EXEC cycle from registered operands,
// captures alu_z and presents the result to writeback (valid/ready).
// Throughput 1 op / 2 cycles; out_valid rises the cycle after EXEC.
// Ports:
//   clk, rst_n (async, active low), flush
//   in_valid/in_ready, in_mode[7:0], in_word, in_src1/in_src2[63:0], in_rd
//   alu_mode[7:0], alu_a/alu_b[63:0] -> ALU;  alu_z[63:0] <- ALU
//   out_valid/out_ready, out_result[63:0], out_rd, out_illegal
//   perf_ops[31:0], perf_stall[31:0]
// Build option: EXU_ALU_ISSUE_PERF_EN enables the perf counters; otherwise
// perf_ops/perf_stall are tied to zero.
// -----------------------------------------------------------------------------
module exu_alu_issue
    import exu_alu_issue_pkg::*;
#(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_mode,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [RD_W-1:0] in_rd,
    output logic [7:0]      alu_mode,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_illegal,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_stall
);

    state_t          r_state;
    logic [7:0]      r_mode;
    logic            r_word;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [RD_W-1:0] r_rd;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic [RD_W-1:0] r_out_rd;
    logic            r_illegal;

    logic            w_legal;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_accept;
    logic [XLEN-1:0] w_result;

    exu_alu_opnd_prep u_prep (
        .i_mode  (r_mode),
        .i_word  (r_word),
        .i_a     (r_a),
        .i_b     (r_b),
        .o_legal (w_legal),
        .o_a     (w_a),
        .o_b     (w_b)
    );

    // flush masks in_ready so a same-cycle accept can never win over it.
    assign in_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    // ALU inputs are only non-zero during EXEC of a legal op.
    always_comb begin
        alu_mode = '0;
        alu_a    = '0;
        alu_b    = '0;
        if ((r_state == EXEC) && w_legal) begin
            alu_mode = r_mode;
            alu_a    = w_a;
            alu_b    = w_b;
        end
    end

    assign w_result = r_word ? {{32{alu_z[31]}}, alu_z[31:0]} : alu_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode      <= '0;
            r_word      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_out_rd    <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            // Accept can only happen in IDLE or in DONE with out_ready.
            if (w_accept) begin
                r_mode <= in_mode;
                r_word <= in_word;
                r_a    <= in_src1;
                r_b    <= in_src2;
                r_rd   <= in_rd;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= EXEC;
                end
                EXEC: begin
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                    r_result    <= w_legal ? w_result : '0;
                    r_illegal   <= !w_legal;
                    r_out_rd    <= r_rd;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? EXEC : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_illegal;

`ifdef EXU_ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_out_valid && out_ready)  r_perf_ops   <= r_perf_ops + 32'd1;
            if (r_out_valid && !out_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_exu_alu_issue.sv
module tb_exu_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_mode;
    logic        in_word;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_rd;
    logic [7:0]  alu_mode;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned n_hs = 0;
    int unsigned exp_stall = 0;

    always #5 clk = ~clk;

    exu_alu_issue #(.RD_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_word     (in_word),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_rd       (in_rd),
        .alu_mode    (alu_mode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_z       (alu_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
    );

    // Plain unsigned combinational ALU, as the core provides it.
    logic signed [63:0] alu_sa;
    assign alu_sa = alu_a;
    always_comb begin
        case (alu_mode)
            8'd0:       alu_z = alu_a + alu_b;
            8'd1:       alu_z = alu_a - alu_b;
            8'd2, 8'd3: alu_z = {63'd0, alu_a < alu_b};
            8'd4:       alu_z = alu_a & alu_b;
            8'd6:       alu_z = alu_a | alu_b;
            8'd7:       alu_z = alu_a ^ alu_b;
            8'd8:       alu_z = alu_a << alu_b[5:0];
            8'd10:      alu_z = alu_sa >>> alu_b[5:0];
            default:    alu_z = '0;
        endcase
    end

    // Architectural reference for the whole op, independent of operand tricks.
    function automatic exp_t ref_op(input logic [7:0] m, input logic w,
                                    input logic [63:0] a, input logic [63:0] b,
                                    input logic [4:0] rd);
        exp_t               e;
        logic signed [63:0] sa;
        logic signed [31:0] sa32;
        logic [31:0]        r32;
        sa        = a;
        sa32      = a[31:0];
        r32       = '0;
        e.rd      = rd;
        e.illegal = 1'b0;
        e.result  = '0;
        if (w) begin
            case (m)
                8'd0:    r32 = a[31:0] + b[31:0];
                8'd1:    r32 = a[31:0] - b[31:0];
                8'd8:    r32 = a[31:0] << b[4:0];
                8'd10:   r32 = sa32 >>> b[4:0];
                default: e.illegal = 1'b1;
            endcase
            if (!e.illegal) e.result = {{32{r32[31]}}, r32};
        end else begin
            case (m)
                8'd0:    e.result = a + b;
                8'd1:    e.result = a - b;
                8'd2:    e.result = (sa < $signed(b)) ? 64'd1 : 64'd0;
                8'd3:    e.result = (a < b) ? 64'd1 : 64'd0;
                8'd4:    e.result = a & b;
                8'd6:    e.result = a | b;
                8'd7:    e.result = a ^ b;
                8'd8:    e.result = a << b[5:0];
                8'd10:   e.result = sa >>> b[5:0];
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic logic [63:0] perf_exp(input int unsigned v);
`ifdef EXU_ALU_ISSUE_PERF_EN
        return 64'(v);
`else
        return 64'(v) & 64'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] m, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input bit push);
        in_mode  = m;
        in_word  = w;
        in_src1  = a;
        in_src2  = b;
        in_rd    = rd;
        in_valid = 1'b1;
        if (push) sb.push_back(ref_op(m, w, a, b, rd));
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_res"}, out_result, e.result);
        check({tag, "_rd"}, 64'(out_rd), 64'(e.rd));
        check1({tag, "_ill"}, out_illegal, e.illegal);
    endtask

    // One op with out_ready high: accept, one EXEC cycle, result in DONE.
    task automatic run_op(input string tag, input logic [7:0] m, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        exp_t e;
        e = ref_op(m, w, a, b, rd);
        @(negedge clk);
        drive(m, w, a, b, rd, 1'b1);
        check1({tag, "_inrdy"}, in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check1({tag, "_v_exec"}, out_valid, 1'b0);
        if (e.illegal) begin
            check({tag, "_alu_a0"}, alu_a, 64'd0);
            check({tag, "_alu_b0"}, alu_b, 64'd0);
            check({tag, "_alu_m0"}, 64'(alu_mode), 64'd0);
        end else begin
            check({tag, "_alu_m"}, 64'(alu_mode), 64'(m));
        end
        @(negedge clk);
        check1({tag, "_v_done"}, out_valid, 1'b1);
        compare_out(tag);
        @(posedge clk);
        n_hs++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = '0;
        in_word   = 1'b0;
        in_src1   = '0;
        in_src2   = '0;
        in_rd     = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_result", out_result, 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);
        check1("rst_illegal", out_illegal, 1'b0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_alu_b", alu_b, 64'd0);
        check("rst_alu_mode", 64'(alu_mode), 64'd0);
        check("rst_perf_ops", 64'(perf_ops), 64'd0);
        check("rst_perf_stall", 64'(perf_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function
        run_op("add",    8'd0,  1'b0, 64'd5, 64'd7, 5'd1);
        run_op("slt",    8'd2,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd2);
        run_op("sltu",   8'd3,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3);
        run_op("slt_np", 8'd2,  1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
        run_op("sub",    8'd1,  1'b0, 64'd3, 64'd5, 5'd5);
        run_op("and",    8'd4,  1'b0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 5'd6);
        run_op("or",     8'd6,  1'b0, 64'hF0F0_0000_0000_0001, 64'h0F0F_0000_0000_0100, 5'd7);
        run_op("xor",    8'd7,  1'b0, 64'hAAAA_AAAA_5555_5555, 64'hFFFF_0000_FFFF_0000, 5'd8);
        run_op("sll65",  8'd8,  1'b0, 64'h0000_0000_0000_0003, 64'd65, 5'd9);
        run_op("sll64",  8'd8,  1'b0, 64'h1234_5678_9ABC_DEF0, 64'd64, 5'd10);
        run_op("sra",    8'd10, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd11);
        run_op("addw",   8'd0,  1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 5'd12);
        run_op("sraw",   8'd10, 1'b1, 64'h0000_0000_8000_0000, 64'd33, 5'd13);
        run_op("sllw",   8'd8,  1'b1, 64'd1, 64'd31, 5'd14);
        run_op("subw",   8'd1,  1'b1, 64'hFFFF_FFFF_0000_0000, 64'd1, 5'd15);
        run_op("ill5",   8'd5,  1'b0, 64'd9, 64'd9, 5'd16);
        run_op("illwslt", 8'd2, 1'b1, 64'd1, 64'd2, 5'd17);
        run_op("ill11",  8'd11, 1'b0, 64'd1, 64'd2, 5'd18);

        // Backpressure: out_ready low for 3 cycles in DONE
        e = ref_op(8'd0, 1'b0, 64'd100, 64'd23, 5'd19);
        @(negedge clk);
        out_ready = 1'b0;
        drive(8'd0, 1'b0, 64'd100, 64'd23, 5'd19, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check1("bp_v_exec", out_valid, 1'b0);
        @(negedge clk);
        check1("bp_v_done", out_valid, 1'b1);
        check("bp_stall0", 64'(perf_stall), perf_exp(exp_stall));
        compare_out("bp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_stall++;
            check1("bp_hold_v", out_valid, 1'b1);
            check("bp_hold_res", out_result, e.result);
            check("bp_hold_rd", 64'(out_rd), 64'(e.rd));
            check1("bp_inrdy", in_ready, 1'b0);
            check("bp_stall", 64'(perf_stall), perf_exp(exp_stall));
        end
        out_ready = 1'b1;
        @(posedge clk);
        n_hs++;
        @(negedge clk);
        check1("bp_release", out_valid, 1'b0);
        check("bp_stall_end", 64'(perf_stall), perf_exp(exp_stall));

        // Back-to-back: new op accepted in the DONE/handshake cycle
        @(negedge clk);
        drive(8'd7, 1'b0, 64'h00FF, 64'h0F0F, 5'd20, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("b2b_a_v", out_valid, 1'b1);
        compare_out("b2b_a");
        drive(8'd1, 1'b0, 64'd10, 64'd20, 5'd21, 1'b1);
        check1("b2b_inrdy", in_ready, 1'b1);
        @(posedge clk);
        n_hs++;
        #1 in_valid = 1'b0;
        @(negedge clk);
        check1("b2b_b_exec", out_valid, 1'b0);
        @(negedge clk);
        check1("b2b_b_v", out_valid, 1'b1);
        compare_out("b2b_b");
        @(posedge clk);
        n_hs++;
        #1;
        check("perf_ops_mid", 64'(perf_ops), perf_exp(n_hs));

        // Flush during EXEC drops the op
        @(negedge clk);
        drive(8'd0, 1'b0, 64'd1, 64'd1, 5'd22, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check1("flush_v0", out_valid, 1'b0);
        check1("flush_inrdy", in_ready, 1'b1);
        @(negedge clk);
        check1("flush_v1", out_valid, 1'b0);

        // Flush beats a simultaneous accept
        drive(8'd0, 1'b0, 64'd3, 64'd4, 5'd23, 1'b0);
        flush = 1'b1;
        #1;
        check1("flush_acc_inrdy", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_acc_alu_a", alu_a, 64'd0);
        check1("flush_acc_v0", out_valid, 1'b0);
        @(negedge clk);
        check1("flush_acc_v1", out_valid, 1'b0);

        run_op("post_flush", 8'd0, 1'b0, 64'd40, 64'd2, 5'd24);
        check("perf_ops_flush", 64'(perf_ops), perf_exp(n_hs));

        // Reset asserted mid-op: op lost, outputs back at reset values
        @(negedge clk);
        drive(8'd0, 1'b0, 64'd77, 64'd1, 5'd25, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1("mrst_v", out_valid, 1'b0);
        check("mrst_res", out_result, 64'd0);
        check("mrst_rd", 64'(out_rd), 64'd0);
        check("mrst_alu_a", alu_a, 64'd0);
        check("mrst_perf_ops", 64'(perf_ops), 64'd0);
        check("mrst_perf_stall", 64'(perf_stall), 64'd0);
        n_hs      = 0;
        exp_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check1("mrst_v_after", out_valid, 1'b0);

        run_op("post_rst", 8'd10, 1'b0, 64'hFFFF_0000_0000_0000, 64'd8, 5'd26);
        check("perf_ops_end", 64'(perf_ops), perf_exp(n_hs));
        check("perf_stall_end", 64'(perf_stall), perf_exp(exp_stall));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
